// File: rtl/param_window_seq_detector_pkg.sv
// Shared definitions for the sliding-window sequence detector: default sizes,
// the fill-counter width helper and the overlap mode encoding.
package param_window_seq_detector_pkg;

    localparam int DEF_WIN_LEN = 4;
    localparam int DEF_CNT_W   = 8;

    localparam logic MODE_OVERLAP    = 1'b1;
    localparam logic MODE_NONOVERLAP = 1'b0;

    // Width of a counter that must hold the values 0..winLen inclusive.
    function automatic int fillWidth(input int winLen);
        return $clog2(winLen + 1);
    endfunction

endpackage

// File: rtl/seq_det_window.sv
// Sliding window shift register plus saturating fill counter.
// win_o and full_o are look-ahead values: the window and the "window full"
// flag as they become if bit_i is shifted in on this edge. The top compares
// against these so that dec rises one cycle after the completing bit.
// Only the newest WIN_LEN-1 bits are stored, because the oldest stored bit
// is shifted out by the very edge whose window is being evaluated.
module seq_det_window
    import param_window_seq_detector_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_i,
    input  logic               clear_i,
    input  logic               bit_i,
    output logic [WIN_LEN-1:0] win_o,
    output logic               full_o
);

    localparam int FW = fillWidth(WIN_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(WIN_LEN);

    logic [WIN_LEN-2:0] win_q;
    logic [WIN_LEN-1:0] win_d;
    logic [FW-1:0]      fill_q;
    logic [FW-1:0]      fill_d;

    // Next window and next fill count, assuming the current bit is shifted in.
    always_comb begin
        win_d  = {win_q, bit_i};
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
    end

    // Window and fill registers: clear wins over shift, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            fill_q <= '0;
        end else if (clear_i) begin
            win_q  <= '0;
            fill_q <= '0;
        end else if (shift_i) begin
            win_q  <= win_d[WIN_LEN-2:0];
            fill_q <= fill_d;
        end
    end

    assign win_o  = win_d;
    assign full_o = (fill_d == FILL_MAX);

endmodule

// File: rtl/param_window_seq_detector.sv
// Sliding-window sequence detector with runtime-loadable pattern and mask.
// Pulses dec for one cycle after the edge that completes a match.
// Optional feature: define SEQDET_COUNT_EN to build a saturating match
// counter on match_cnt; otherwise match_cnt is tied to zero.
module param_window_seq_detector
    import param_window_seq_detector_pkg::*;
#(
    parameter int                 WIN_LEN     = DEF_WIN_LEN,
    parameter logic [WIN_LEN-1:0] DEF_PATTERN = 4'b1110,
    parameter int                 CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [WIN_LEN-1:0] cfg_pattern,
    input  logic [WIN_LEN-1:0] cfg_mask,
    input  logic               cfg_overlap,
    output logic               dec,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [WIN_LEN-1:0] pattern_q;
    logic [WIN_LEN-1:0] mask_q;
    logic               overlap_q;
    logic               dec_q;
    logic [WIN_LEN-1:0] winNext;
    logic               fullNext;
    logic               shift;
    logic               hit;
    logic               clear;

    // A loaded configuration drops the bit offered on the same edge.
    assign shift = in_valid && !cfg_load;
    assign hit   = shift && fullNext && (((winNext ^ pattern_q) & mask_q) == '0);
    assign clear = cfg_load || (hit && (overlap_q == MODE_NONOVERLAP));

    seq_det_window #(
        .WIN_LEN (WIN_LEN)
    ) u_window (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_i (shift),
        .clear_i (clear),
        .bit_i   (in),
        .win_o   (winNext),
        .full_o  (fullNext)
    );

    // Configuration registers: reset to the default pattern, full mask, overlap on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= DEF_PATTERN;
            mask_q    <= '1;
            overlap_q <= MODE_OVERLAP;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            mask_q    <= cfg_mask;
            overlap_q <= cfg_overlap;
        end
    end

    // Registered match pulse; hit is already low on load and idle edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else begin
            dec_q <= hit;
        end
    end

    assign dec = dec_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating match counter, cleared whenever a new configuration is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cfg_load) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule
